// File: rtl/run_controller.sv
// Host-side run sequencer: debounces the run key, issues a one-cycle startN pulse,
// then times the processor run until processDone rises or the watchdog expires.
module run_controller #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CNT_W           = 32,
    parameter int unsigned TIMEOUT_CYCLES  = 1000000
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             keyN,
    input  logic             processor_ready,
    input  logic             processDone,
    output logic             startN,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_count
);

    localparam int unsigned     DEB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] WDOG_VAL = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam bit               WDOG_EN  = (TIMEOUT_CYCLES != 0);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_READY,
        ST_START,
        ST_RUN,
        ST_FINISH,
        ST_TIMEOUT
    } state_t;

    logic             key_meta;
    logic             key_sync;
    logic             key_stable;
    logic [DEB_W-1:0] deb_cnt;
    logic             deb_take_c;
    logic             press_c;
    logic             done_q;
    logic             done_evt_c;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] count_next;

    // Key synchronizer and debounce filter
    assign deb_take_c = (key_sync != key_stable) && (deb_cnt == DEB_LAST);
    assign press_c    = deb_take_c && key_stable && !key_sync;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            key_meta   <= 1'b1;
            key_sync   <= 1'b1;
            key_stable <= 1'b1;
            deb_cnt    <= '0;
        end else begin
            key_meta <= keyN;
            key_sync <= key_meta;
            if (key_sync == key_stable) begin
                deb_cnt <= '0;
            end else if (deb_take_c) begin
                key_stable <= key_sync;
                deb_cnt    <= '0;
            end else begin
                deb_cnt <= deb_cnt + DEB_W'(1);
            end
        end
    end

    // Rising edge of processDone
    assign done_evt_c = processDone && !done_q;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            done_q <= 1'b0;
        end else begin
            done_q <= processDone;
        end
    end

    // Next-state and run counter logic
    always_comb begin
        state_next = state;
        count_next = cycle_count;
        case (state)
            ST_IDLE: begin
                if (press_c) state_next = ST_WAIT_READY;
            end
            ST_WAIT_READY: begin
                if (processor_ready) state_next = ST_START;
            end
            ST_START: begin
                count_next = '0;
                state_next = ST_RUN;
            end
            ST_RUN: begin
                if (done_evt_c) begin
                    state_next = ST_FINISH;
                end else if (WDOG_EN && (cycle_count == WDOG_VAL)) begin
                    state_next = ST_TIMEOUT;
                end else if (cycle_count != CNT_MAX) begin
                    count_next = cycle_count + CNT_W'(1);
                end
            end
            ST_FINISH, ST_TIMEOUT: begin
                if (press_c) state_next = ST_WAIT_READY;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State register; outputs registered from the next state so they align with it
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state       <= ST_IDLE;
            startN      <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout     <= 1'b0;
            cycle_count <= '0;
        end else begin
            state       <= state_next;
            startN      <= (state_next != ST_START);
            busy        <= (state_next == ST_WAIT_READY) || (state_next == ST_START) ||
                           (state_next == ST_RUN);
            done        <= (state_next == ST_FINISH);
            timeout     <= (state_next == ST_TIMEOUT);
            cycle_count <= count_next;
        end
    end

endmodule
